// File: rtl/pdm_mic_decimator.sv
// PDM mic front end: bit-clock generator, 2-flop input sync, 3rd-order CIC decimator by 2^DECIMATION_LOG2.
// Latency: sample 2 clocks after the block-completing mic_clk fall; no backpressure, audio_o is held until the next pulse.
module pdm_mic_decimator #(
    parameter int SAMPLE_DEPTH    = 8,
    parameter int CLK_DIV         = 4,
    parameter int DECIMATION_LOG2 = 6
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_reset_ni,
    input  logic                    enable_i,
    input  logic                    mic_data_i,
    output logic                    mic_clk_o,
    output logic [SAMPLE_DEPTH-1:0] audio_o,
    output logic                    sample_valid_o
);

    localparam int W     = 3 * DECIMATION_LOG2 + 2;
    localparam int SHIFT = 3 * DECIMATION_LOG2 - SAMPLE_DEPTH + 1;
    localparam int CW    = $clog2(CLK_DIV);

    localparam logic signed [W-1:0] SAT_MAX = W'((1 << (SAMPLE_DEPTH - 1)) - 1);
    localparam logic signed [W-1:0] SAT_MIN = -SAT_MAX - W'(1);

    logic                       sync1_q, sync1_d;
    logic                       sync2_q, sync2_d;
    logic [CW-1:0]              div_q, div_d;
    logic                       mic_clk_q, mic_clk_d;
    logic [DECIMATION_LOG2-1:0] bit_q, bit_d;
    logic [W-1:0]               i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic [W-1:0]               d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [W-1:0]               c3_q, c3_d;
    logic                       dec_strobe_q, dec_strobe_d;
    logic                       out_strobe_q, out_strobe_d;
    logic [SAMPLE_DEPTH-1:0]    audio_q, audio_d;
    logic                       valid_q, valid_d;

    logic                       div_last;
    logic [W-1:0]               x;
    logic [W-1:0]               c1, c2, c3;
    logic signed [W-1:0]        shifted;
    logic signed [W-1:0]        sat;

    assign div_last = (div_q == CW'(CLK_DIV - 1));
    assign x        = sync2_q ? W'(1) : {W{1'b1}};
    assign shifted  = $signed(c3_q) >>> SHIFT;

    always_comb begin
        sat = shifted;
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX;
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN;
        end
    end

    always_comb begin
        sync1_d      = mic_data_i;
        sync2_d      = sync1_q;
        div_d        = div_q;
        mic_clk_d    = mic_clk_q;
        bit_d        = bit_q;
        i1_d         = i1_q;
        i2_d         = i2_q;
        i3_d         = i3_q;
        d1_d         = d1_q;
        d2_d         = d2_q;
        d3_d         = d3_q;
        c3_d         = c3_q;
        dec_strobe_d = 1'b0;
        out_strobe_d = 1'b0;
        audio_d      = audio_q;
        valid_d      = 1'b0;
        c1           = '0;
        c2           = '0;
        c3           = '0;

        if (!enable_i) begin
            // Stop clears the whole filter state; only the last sample is kept.
            div_d     = '0;
            mic_clk_d = 1'b0;
            bit_d     = '0;
            i1_d      = '0;
            i2_d      = '0;
            i3_d      = '0;
            d1_d      = '0;
            d2_d      = '0;
            d3_d      = '0;
        end else begin
            if (div_last) begin
                div_d     = '0;
                mic_clk_d = ~mic_clk_q;
            end else begin
                div_d = div_q + CW'(1);
            end

            // Falling edge of mic_clk is the PDM sample point.
            if (div_last && mic_clk_q) begin
                i1_d         = i1_q + x;
                i2_d         = i2_q + i1_d;
                i3_d         = i3_q + i2_d;
                bit_d        = bit_q + DECIMATION_LOG2'(1);
                dec_strobe_d = (bit_q == {DECIMATION_LOG2{1'b1}});
            end

            if (dec_strobe_q) begin
                c1           = i3_q - d1_q;
                c2           = c1 - d2_q;
                c3           = c2 - d3_q;
                d1_d         = i3_q;
                d2_d         = c1;
                d3_d         = c2;
                c3_d         = c3;
                out_strobe_d = 1'b1;
            end

            if (out_strobe_q) begin
                audio_d = sat[SAMPLE_DEPTH-1:0];
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            div_q        <= '0;
            mic_clk_q    <= 1'b0;
            bit_q        <= '0;
            i1_q         <= '0;
            i2_q         <= '0;
            i3_q         <= '0;
            d1_q         <= '0;
            d2_q         <= '0;
            d3_q         <= '0;
            c3_q         <= '0;
            dec_strobe_q <= 1'b0;
            out_strobe_q <= 1'b0;
            audio_q      <= '0;
            valid_q      <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            div_q        <= div_d;
            mic_clk_q    <= mic_clk_d;
            bit_q        <= bit_d;
            i1_q         <= i1_d;
            i2_q         <= i2_d;
            i3_q         <= i3_d;
            d1_q         <= d1_d;
            d2_q         <= d2_d;
            d3_q         <= d3_d;
            c3_q         <= c3_d;
            dec_strobe_q <= dec_strobe_d;
            out_strobe_q <= out_strobe_d;
            audio_q      <= audio_d;
            valid_q      <= valid_d;
        end
    end

    assign mic_clk_o      = mic_clk_q;
    assign audio_o        = audio_q;
    assign sample_valid_o = valid_q;

endmodule

// File: tb/tb_pdm_mic_decimator.sv
// Directed bench for pdm_mic_decimator at default parameters (R=64, CLK_DIV=4, 8-bit output).
module tb_pdm_mic_decimator;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              mic_data = 1'b0;
    logic              mic_clk;
    logic signed [7:0] audio;
    logic              valid;

    pdm_mic_decimator #(
        .SAMPLE_DEPTH   (8),
        .CLK_DIV        (4),
        .DECIMATION_LOG2(6)
    ) dut (
        .wb_clk_i      (clk),
        .wb_reset_ni   (rst_n),
        .enable_i      (enable),
        .mic_data_i    (mic_data),
        .mic_clk_o     (mic_clk),
        .audio_o       (audio),
        .sample_valid_o(valid)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int got_audio [0:63];
    int got_edge  [0:63];
    int n_got;
    int first_rise;
    int second_rise;

    localparam int PAT_ONES  = 0;
    localparam int PAT_ZEROS = 1;
    localparam int PAT_ALT   = 2;

    typedef struct {
        int    pat;
        int    idx;
        int    exp;
        string name;
    } vec_t;

    vec_t vecs [0:7];

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Enable from a stopped state, drive the pattern, and record pulses; edge 1 is the first posedge with enable=1.
    task automatic run(input int pat, input int npulses, input int budget);
        int edge_n;
        logic prev_clk;
        n_got       = 0;
        edge_n      = 0;
        first_rise  = 0;
        second_rise = 0;
        mic_data    = (pat == PAT_ONES);
        repeat (3) @(negedge clk);
        prev_clk = mic_clk;
        enable   = 1'b1;
        while (n_got < npulses && edge_n < budget) begin
            @(posedge clk);
            @(negedge clk);
            edge_n++;
            if (!prev_clk && mic_clk) begin
                if (first_rise == 0) first_rise = edge_n;
                else if (second_rise == 0) second_rise = edge_n;
                if (pat == PAT_ALT) mic_data = ~mic_data;
            end
            prev_clk = mic_clk;
            if (valid) begin
                got_audio[n_got] = int'(audio);
                got_edge[n_got]  = edge_n;
                n_got++;
            end
        end
        check("pulse_count", n_got, npulses);
        enable = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Edges from the current negedge (enable already 1) to the next valid pulse.
    task automatic edges_to_pulse(output int edge_n, input int budget);
        edge_n = 0;
        while (edge_n < budget) begin
            @(posedge clk);
            @(negedge clk);
            edge_n++;
            if (valid) break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int pulses;
        int changes;

        vecs[0] = '{PAT_ONES,  1,   22, "ones_pulse1"};
        vecs[1] = '{PAT_ONES,  2,  107, "ones_pulse2"};
        vecs[2] = '{PAT_ONES,  3,  127, "ones_pulse3"};
        vecs[3] = '{PAT_ZEROS, 1,  -23, "zeros_pulse1"};
        vecs[4] = '{PAT_ZEROS, 2, -108, "zeros_pulse2"};
        vecs[5] = '{PAT_ZEROS, 3, -128, "zeros_pulse3"};
        vecs[6] = '{PAT_ALT,   3,    0, "alt_pulse3"};
        vecs[7] = '{PAT_ALT,   4,    0, "alt_pulse4"};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_mic_clk", int'(mic_clk), 0);
        check("reset_audio", int'(audio), 0);
        check("reset_valid", int'(valid), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run(vecs[i].pat, vecs[i].idx, 3000);
            check(vecs[i].name, got_audio[vecs[i].idx - 1], vecs[i].exp);
        end

        // Long all-ones run: integrators wrap many times, timing checked along the way
        run(PAT_ONES, 40, 25000);
        check("first_rise_edge", first_rise, 4);
        check("mic_clk_period", second_rise - first_rise, 8);
        check("first_pulse_edge", got_edge[0], 514);
        for (int p = 1; p < 40; p++) begin
            check("cadence", got_edge[p] - got_edge[p-1], 512);
        end
        for (int p = 2; p < 40; p++) begin
            check("wrap_ones", got_audio[p], 127);
        end

        // Enable drop mid-block (bit counter ~30); audio holds 127 from above
        mic_data = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        pulses = 0;
        for (int k = 0; k < 245; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) pulses++;
        end
        check("no_early_pulse", pulses, 0);
        check("mic_clk_high_before_drop", int'(mic_clk), 1);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mic_clk_low_after_drop", int'(mic_clk), 0);
        pulses  = 0;
        changes = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid) pulses++;
            if (int'(audio) != 127) changes++;
        end
        check("no_pulse_while_disabled", pulses, 0);
        check("audio_held_while_disabled", changes, 0);
        check("audio_held_value", int'(audio), 127);
        enable = 1'b1;
        edges_to_pulse(e, 1000);
        check("reenable_pulse_edge", e, 514);
        check("reenable_audio_clean", int'(audio), -23);
        enable = 1'b0;
        repeat (3) @(negedge clk);

        // Async reset mid-block with toggling data
        enable = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            @(negedge clk);
            mic_data = 1'($urandom_range(0, 1));
        end
        check("mic_clk_high_before_reset", int'(mic_clk), 1);
        check("audio_nonzero_before_reset", int'(audio), -23);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mic_clk", int'(mic_clk), 0);
        check("async_reset_audio", int'(audio), 0);
        check("async_reset_valid", int'(valid), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mic_data = ~mic_data;
        end
        mic_data = 1'b1;
        rst_n    = 1'b1;
        edges_to_pulse(e, 1000);
        check("post_reset_pulse_edge", e, 514);
        check("post_reset_audio", int'(audio), 22);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
